prod_accum: RTL
===============

# prod_accum

Product accumulator that sits directly downstream of the pipelined `mul` multiplier. It consumes the 2N-bit product stream `P`, qualified by a valid strobe that the upstream control delays by `mul`'s 3-cycle latency. It sums exactly `LEN` products per block and presents the sum on a valid/ready output port. Together with `mul`, it forms the team's multiply-accumulate (dot-product) path.

## Interface
- `N`, default 4: operand width of the upstream multiplier; the product input is 2N bits.
- `LEN`, default 8: number of products summed per block; must be ≥ 2.
- `ACC_W`, default 2N+$clog2(LEN): accumulator and result width; must be ≥ 2N.
- `clk`, input, 1: the single clock; all logic is rising-edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: single-cycle pulse that opens a new block.
- `p_valid`, input, 1: `P` carries a product this cycle.
- `P`, input, 2N: product from `mul`, unsigned.
- `acc_valid`, output, 1: `acc_out` holds a completed sum.
- `acc_ready`, input, 1: downstream accepts `acc_out`.
- `acc_out`, output, ACC_W: block sum, unsigned.
- `busy`, output, 1: high in ACCUM or DONE.
- `overflow`, output, 1: sticky; a sum exceeded 2^ACC_W−1 during the current or last block.
- `drop`, output, 1: sticky; `p_valid` arrived while not in ACCUM.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - `start` → ACCUM; clear acc, count, `overflow` and `drop`.
  - `p_valid` → set `drop`; the product is discarded.
- ACCUM:
  - On each `p_valid`: acc ← acc + zero-extended `P`; count++.
  - When `p_valid` arrives with count == LEN−1: acc + `P` is written to `acc_out`, `acc_valid` is set, FSM → DONE, count → 0.
  - Cycles without `p_valid` are bubbles; state is held.
- ACCUM, `start` re-asserted:
  - The block restarts: acc, count, `overflow` and `drop` are cleared, and any `p_valid` in that same cycle is discarded.
  - Rationale: the upstream pipeline was flushed.
- DONE:
  - `acc_out` and `acc_valid` are held stable until `acc_valid && acc_ready`. That cycle drops `acc_valid`, and FSM → IDLE on the next edge.
  - `start` in DONE is ignored.
  - `p_valid` in DONE sets `drop` and the product is discarded.
- Arithmetic:
  - Unsigned only.
  - Overflow is detected on the carry out of the ACC_W-bit add.
  - Wrap or saturate per Configuration.
- Reset values: FSM IDLE; acc, count, `acc_out`, `acc_valid`, `busy`, `overflow` and `drop` all 0.
- `rst` mid-block or mid-handshake: everything returns to reset values on that edge. The partial sum and any pending result are lost.

## Timing
- Input sampling: `P` and `p_valid` are sampled on the same edge. Upstream must delay its operand valid by 3 cycles so it aligns with `mul.P`.
- Latency: `acc_valid` rises on the edge that accepts the LEN-th product, i.e. 1 cycle after that product is presented.
- Throughput, best case: LEN+2 cycles per block (LEN accepts, 1 DONE cycle with immediate ready, 1 IDLE cycle for `start`).
- `busy`: registered; equals (state != IDLE).
- Flag timing:
  - `drop` and `overflow` set on the edge following the offending cycle.
  - They clear only on an accepted `start` or on `rst`.
- `acc_out` stability: must not change while `acc_valid` is high.

## Configuration
- Macro: `PROD_ACCUM_SAT_EN`.
- Defined: the accumulator saturates.
  - On carry, acc is clamped to 2^ACC_W−1 and stays there until the block ends.
  - `overflow` is set.
- Undefined: the accumulator wraps modulo 2^ACC_W.
  - `overflow` is still set on the first carry.
- Both builds: identical ports and timing.

## Structure
- Package `prod_accum_pkg` holds:
  - the state enum `accum_state_t` (IDLE, ACCUM, DONE);
  - the width helper `acc_w_default(N, LEN)`;
  - the count-width constant function.
- Sub-module `accum_add`: combinational ACC_W-bit adder with carry out and the macro-gated saturation. It is instantiated once in the datapath.
- FSM, counter and output register live in `prod_accum`.

## Test plan
- N=4, LEN=8, default ACC_W=11: `start`, then 8 back-to-back `P`=225 → `acc_out`=1800, `acc_valid` 1 cycle after the 8th product, `overflow`=0.
- Bubbles and backpressure:
  - Stimulus: `P` = 1..8 with `p_valid` gaps between samples; `acc_ready` held low for 5 cycles after `acc_valid`.
  - Required: `acc_out`=36 held stable throughout; IDLE follows the handshake.
- Narrow accumulator: ACC_W=10, 8×225 →
  - with `PROD_ACCUM_SAT_EN`: `acc_out`=1023, `overflow`=1;
  - without it: `acc_out`=776, `overflow`=1.
- Stray product: `p_valid` with `P`=50 in IDLE → `drop`=1 and the sum is unaffected. The next `start` clears `drop`.
- Restart: `start` after 3 products, then 8×10 → `acc_out`=80.
- Reset mid-block: `rst` after 5 products → all outputs 0, FSM IDLE. A new block of 8×2 → `acc_out`=16.

Source files
------------

// File: rtl/prod_accum_pkg.sv
// prod_accum_pkg: shared types and width helpers for the product accumulator.
// Holds the FSM state encoding, the default accumulator width rule and the
// block-counter width rule, so the top and the bench agree on them.
package prod_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } accum_state_t;

  // Default accumulator width: enough headroom for LEN full-scale products.
  function automatic int acc_w_default(input int n, input int len);
    return 2 * n + $clog2(len);
  endfunction

  // Width of the per-block product counter (counts 0 .. LEN-1).
  function automatic int cnt_w(input int len);
    return ($clog2(len) < 1) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/accum_add.sv
// accum_add: combinational W-bit unsigned adder with carry out.
// Build option PROD_ACCUM_SAT_EN: when defined, a carry clamps the sum to
// all-ones; when undefined, the sum wraps modulo 2^W. The carry output is
// raw in both builds so the caller can flag overflow either way.
module accum_add #(
  parameter int W = 11
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] full;

  // One-bit-wider add exposes the carry; saturation is applied on top of it.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
    full  = {1'b0, a} + {1'b0, b};
    carry = full[W];
`ifdef PROD_ACCUM_SAT_EN
    sum   = carry ? {W{1'b1}} : full[W-1:0];
`else
    sum   = full[W-1:0];
`endif
  end

endmodule

// File: rtl/prod_accum.sv
// prod_accum: sums exactly LEN unsigned products per block from the pipelined
// multiplier and presents the block sum on a valid/ready port.
// Build option PROD_ACCUM_SAT_EN selects a saturating accumulator (see
// accum_add); without it the accumulator wraps. Ports and timing are the
// same in both builds.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int N     = 4,
  parameter int LEN   = 8,
  parameter int ACC_W = acc_w_default(N, LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             p_valid,
  input  logic [2*N-1:0]   P,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             busy,
  output logic             overflow,
  output logic             drop
);

  localparam int PW = 2 * N;
  localparam int CW = cnt_w(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  accum_state_t     state;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    count;
  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;

  // Products are unsigned, so widening is a plain zero-extension.
  assign p_ext = ACC_W'(P[PW-1:0]);

  accum_add #(.W(ACC_W)) u_add (
    .a     (acc),
    .b     (p_ext),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Block FSM, product counter, sticky flags and the registered result port.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      drop      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            busy     <= 1'b1;
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop     <= 1'b0;
          end else if (p_valid) begin
            drop <= 1'b1;
          end
        end

        ACCUM: begin
          if (start) begin
            // Upstream was flushed: restart the block and discard any product
            // that arrives in this same cycle.
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop     <= 1'b0;
          end else if (p_valid) begin
            acc <= add_sum;
            if (add_carry) begin
              overflow <= 1'b1;
            end
            if (count == LAST) begin
              acc_out   <= add_sum;
              acc_valid <= 1'b1;
              count     <= '0;
              state     <= DONE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end

        DONE: begin
          // acc_out is only written on block completion, so it holds while
          // the result waits for acc_ready; start is ignored here.
          if (p_valid) begin
            drop <= 1'b1;
          end
          if (acc_ready) begin
            acc_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          acc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
